m68k_region_decoder: RTL and testbench
======================================

Name: m68k_region_decoder

Overview:
Parametrised, registered 68000 address-region decoder with a cycle-accurate DTACK/BERR generator. It replaces ad-hoc combinational range compares with NUM_REGIONS base/mask windows. Each window has a wait-state count and an optional external-ready handshake (e.g. SDRAM-backed ROM). It sits between the 68000 bus and the per-region memory and peripheral blocks, and drives the CPU's dtack_n and berr_n.

Parameters:
NUM_REGIONS, 4, number of decoded windows; lower index wins on overlap
ADDR_W, 24, CPU address width
REGION_BASE, {24'h0b0000,24'h0e0000,24'h070000,24'h000000}, packed ADDR_W bits per region; region 0 is in the LSBs
REGION_MASK, {24'hffc000,24'hffff00,24'hffc000,24'hfc0000}, packed; hit when (a & mask) == (base & mask)
REGION_WAIT, {4'd0,4'd1,4'd0,4'd0}, packed 4-bit wait states per region
REGION_EXT, 4'b1000, per-region flag: also wait for ext_ready
BERR_TIMEOUT, 255, cycles before bus error on an unmapped or stalled access

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
cpu_a  in  ADDR_W  68000 byte address
cpu_as_n  in  1  address strobe, active low
cpu_uds_n  in  1  upper data strobe, active low
cpu_lds_n  in  1  lower data strobe, active low
ext_ready  in  1  external ready, sampled only for EXT regions
region_cs  out  NUM_REGIONS  registered one-hot chip selects
region_idx  out  max(1,$clog2(NUM_REGIONS))  index of the active region
hit  out  1  a mapped access is in progress
dtack_n  out  1  data transfer acknowledge to the CPU
berr_n  out  1  bus error to the CPU

Behaviour:
- Clock, reset and flop rules: single clock domain, clk; reset is asynchronous and active-high. All flops clear on reset to region_cs=0, region_idx=0, hit=0, dtack_n=1, berr_n=1, state=IDLE and counters=0.
- Cycle start condition: cpu_as_n==0 and (cpu_uds_n==0 or cpu_lds_n==0), sampled in IDLE. An address strobe with both data strobes high does not start a cycle.
- Decode: combinational priority encoder over the regions, lowest index first. The result is registered on the start edge.
- States:
  - IDLE: on the start condition with a hit, load region_cs, region_idx and hit, set wcnt = REGION_WAIT[idx] and tcnt = 0, then go to WAIT. On a miss go to UNMAP with tcnt = 0.
  - WAIT: each cycle, wcnt decrements when nonzero and tcnt increments. Go to ACK on the edge where wcnt==0 and (EXT[idx]==0 or ext_ready==1). Go to BERR if tcnt reaches BERR_TIMEOUT first.
  - ACK: dtack_n=0, with selects held. When cpu_as_n==1 is sampled, drive dtack_n=1 and clear region_cs and hit, then go to IDLE.
  - UNMAP: tcnt increments. At BERR_TIMEOUT go to BERR.
  - BERR: berr_n=0. When cpu_as_n==1 is sampled, drive berr_n=1, then go to IDLE.
- Latency: let the start edge be N. Then:
  - region_cs is valid after edge N.
  - dtack_n falls after edge N+1+W when not EXT.
  - For EXT regions, dtack_n falls on the first edge at or after N+1+W where ext_ready is sampled high.
- Abort: if cpu_as_n is sampled high in WAIT or UNMAP, clear all selects, keep dtack_n and berr_n high, and return to IDLE.
- Exclusivity: dtack_n and berr_n are never low simultaneously. region_cs is always one-hot or zero.
- Back-to-back cycles: IDLE needs one cycle with cpu_as_n sampled high before a new start. A strobe that stays low after ACK does not re-trigger.
- Address stability: the address is not re-sampled after the start edge. Address changes mid-cycle are ignored.
- Counter widths: tcnt is $clog2(BERR_TIMEOUT+1) bits and saturates; wcnt is 4 bits.
- Reset mid-cycle: returns to IDLE immediately with all outputs at their reset values.

Test Plan:
- Read 0x001234, UDS low: region_cs=4'b0001 and idx=0 after edge N; dtack_n low after edge N+1; release AS, then dtack_n=1 and region_cs=0 one edge later.
- Read 0x0E0042, wait=1: region_cs=4'b0100; dtack_n low after edge N+2, not N+1.
- Access 0x0B0010 (EXT) with ext_ready held low for 5 cycles, then high: dtack_n falls on the edge after ready is sampled high, with region_cs=4'b1000 throughout.
- Access 0x200000 (unmapped): region_cs=0 and hit=0; berr_n low after BERR_TIMEOUT (255) cycles and held until AS rises; dtack_n stays 1.
- EXT access with ext_ready held low for 300 cycles: berr_n low at tcnt=255, dtack_n never low. Separately, AS released during WAIT: selects clear and no acknowledge is issued.
- Assert reset during ACK: dtack_n=1 and region_cs=0 asynchronously. Separately, AS low with both UDS and LDS high: no cycle starts.

Source files
------------

// File: rtl/m68k_region_decoder.sv
// 68000 address-region decoder: registered base/mask window selects plus a
// DTACK/BERR generator with per-region wait states and optional external ready.
module m68k_region_decoder #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W = 24,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
    {24'h0b0000, 24'h0e0000, 24'h070000, 24'h000000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK =
    {24'hffc000, 24'hffff00, 24'hffc000, 24'hfc0000},
  parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = {4'd0, 4'd1, 4'd0, 4'd0},
  parameter logic [NUM_REGIONS-1:0] REGION_EXT = 4'b1000,
  parameter int BERR_TIMEOUT = 255,
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      cpu_a,
  input  logic                   cpu_as_n,
  input  logic                   cpu_uds_n,
  input  logic                   cpu_lds_n,
  input  logic                   ext_ready,
  output logic [NUM_REGIONS-1:0] region_cs,
  output logic [IDX_W-1:0]       region_idx,
  output logic                   hit,
  output logic                   dtack_n,
  output logic                   berr_n
);

  localparam int TCNT_W = $clog2(BERR_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LIMIT = TCNT_W'(BERR_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_UNMAP,
    S_BERR
  } state_t;

  state_t                 state_q;
  logic [NUM_REGIONS-1:0] cs_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   hit_q;
  logic                   dtack_n_q;
  logic                   berr_n_q;
  logic [3:0]             wcnt_q;
  logic [TCNT_W-1:0]      tcnt_q;

  logic                   start;
  logic                   dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic [NUM_REGIONS-1:0] dec_cs;
  logic [TCNT_W-1:0]      tcnt_inc;
  logic                   ext_sel;
  logic                   wait_done;

  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    if (v == {TCNT_W{1'b1}}) sat_inc = v;
    else                     sat_inc = v + 1'b1;
  endfunction

  assign start = !cpu_as_n && (!cpu_uds_n || !cpu_lds_n);

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    dec_cs  = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((cpu_a & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
          (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W])) begin
        dec_hit   = 1'b1;
        dec_idx   = IDX_W'(i);
        dec_cs    = '0;
        dec_cs[i] = 1'b1;
      end
    end
  end

  assign tcnt_inc  = sat_inc(tcnt_q);
  assign ext_sel   = REGION_EXT[idx_q];
  assign wait_done = (wcnt_q == 4'd0) && (!ext_sel || ext_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cs_q      <= '0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tcnt_q <= '0;
            if (dec_hit) begin
              cs_q    <= dec_cs;
              idx_q   <= dec_idx;
              hit_q   <= 1'b1;
              wcnt_q  <= REGION_WAIT[dec_idx*4 +: 4];
              state_q <= S_WAIT;
            end else begin
              state_q <= S_UNMAP;
            end
          end
        end
        S_WAIT: begin
          if (cpu_as_n) begin
            cs_q    <= '0;
            hit_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            if (wcnt_q != 4'd0) wcnt_q <= wcnt_q - 4'd1;
            tcnt_q <= tcnt_inc;
            // An acknowledge on the same edge as the timeout takes precedence.
            if (wait_done) begin
              dtack_n_q <= 1'b0;
              state_q   <= S_ACK;
            end else if (tcnt_inc == TCNT_LIMIT) begin
              cs_q     <= '0;
              hit_q    <= 1'b0;
              berr_n_q <= 1'b0;
              state_q  <= S_BERR;
            end
          end
        end
        S_ACK: begin
          if (cpu_as_n) begin
            dtack_n_q <= 1'b1;
            cs_q      <= '0;
            hit_q     <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_UNMAP: begin
          if (cpu_as_n) begin
            state_q <= S_IDLE;
          end else begin
            tcnt_q <= tcnt_inc;
            if (tcnt_inc == TCNT_LIMIT) begin
              berr_n_q <= 1'b0;
              state_q  <= S_BERR;
            end
          end
        end
        S_BERR: begin
          if (cpu_as_n) begin
            berr_n_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign region_cs  = cs_q;
  assign region_idx = idx_q;
  assign hit        = hit_q;
  assign dtack_n    = dtack_n_q;
  assign berr_n     = berr_n_q;

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Directed bench for m68k_region_decoder: decode, wait states, external
// ready, bus-error timeout, abort, reset during ACK and back-to-back cycles.
module tb_m68k_region_decoder;

  logic        clk;
  logic        reset;
  logic [23:0] cpu_a;
  logic        cpu_as_n;
  logic        cpu_uds_n;
  logic        cpu_lds_n;
  logic        ext_ready;
  logic [3:0]  region_cs;
  logic [1:0]  region_idx;
  logic        hit;
  logic        dtack_n;
  logic        berr_n;

  int chk_cnt;
  int pass_cnt;

  m68k_region_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_a      (cpu_a),
    .cpu_as_n   (cpu_as_n),
    .cpu_uds_n  (cpu_uds_n),
    .cpu_lds_n  (cpu_lds_n),
    .ext_ready  (ext_ready),
    .region_cs  (region_cs),
    .region_idx (region_idx),
    .hit        (hit),
    .dtack_n    (dtack_n),
    .berr_n     (berr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cpu_as_n  = 1'b1;
    cpu_uds_n = 1'b1;
    cpu_lds_n = 1'b1;
    ext_ready = 1'b0;
  endtask

  task automatic test_reset();
    chk_cnt++;
    if ({region_cs, region_idx, hit} !== 7'b0000_00_0)
      $display("FAIL reset_sel: cs/idx/hit=%b required 0000000", {region_cs, region_idx, hit});
    else pass_cnt++;
    chk_cnt++;
    if ({dtack_n, berr_n} !== 2'b11)
      $display("FAIL reset_strobes: dtack/berr=%b required 11", {dtack_n, berr_n});
    else pass_cnt++;
  endtask

  task automatic test_read_r0();
    cpu_a = 24'h001234; cpu_as_n = 1'b0; cpu_uds_n = 1'b0;
    tick();
    chk_cnt++;
    if ({region_cs, region_idx, hit, dtack_n} !== 8'b0001_00_1_1)
      $display("FAIL r0_decode: cs/idx/hit/dtack=%b required 00010011", {region_cs, region_idx, hit, dtack_n});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({dtack_n, berr_n, region_cs} !== 6'b0_1_0001)
      $display("FAIL r0_ack: dtack/berr/cs=%b required 010001", {dtack_n, berr_n, region_cs});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (dtack_n !== 1'b0)
      $display("FAIL r0_ack_hold: dtack=%b required 0", dtack_n);
    else pass_cnt++;
    bus_idle();
    tick();
    chk_cnt++;
    if ({dtack_n, region_cs, hit} !== 6'b1_0000_0)
      $display("FAIL r0_release: dtack/cs/hit=%b required 100000", {dtack_n, region_cs, hit});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_wait_r2();
    cpu_a = 24'h0E0042; cpu_as_n = 1'b0; cpu_lds_n = 1'b0;
    tick();
    chk_cnt++;
    if ({region_cs, region_idx} !== 6'b0100_10)
      $display("FAIL r2_decode: cs/idx=%b required 010010", {region_cs, region_idx});
    else pass_cnt++;
    cpu_a = 24'h001234;
    tick();
    chk_cnt++;
    if (dtack_n !== 1'b1)
      $display("FAIL r2_no_early_ack: dtack=%b required 1", dtack_n);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({dtack_n, region_cs, region_idx} !== 7'b0_0100_10)
      $display("FAIL r2_ack_stable_addr: dtack/cs/idx=%b required 0010010", {dtack_n, region_cs, region_idx});
    else pass_cnt++;
    bus_idle();
    tick();
    chk_cnt++;
    if ({dtack_n, region_cs} !== 5'b1_0000)
      $display("FAIL r2_release: dtack/cs=%b required 10000", {dtack_n, region_cs});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_ext_ready();
    logic bad;
    cpu_a = 24'h0B0010; cpu_as_n = 1'b0; cpu_uds_n = 1'b0; ext_ready = 1'b0;
    tick();
    chk_cnt++;
    if ({region_cs, region_idx} !== 6'b1000_11)
      $display("FAIL ext_decode: cs/idx=%b required 100011", {region_cs, region_idx});
    else pass_cnt++;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dtack_n !== 1'b1 || region_cs !== 4'b1000) bad = 1'b1;
    end
    chk_cnt++;
    if (bad)
      $display("FAIL ext_stall: dtack/cs=%b required 11000 while ready low", {dtack_n, region_cs});
    else pass_cnt++;
    ext_ready = 1'b1;
    tick();
    chk_cnt++;
    if ({dtack_n, region_cs} !== 5'b0_1000)
      $display("FAIL ext_ack: dtack/cs=%b required 01000", {dtack_n, region_cs});
    else pass_cnt++;
    bus_idle();
    tick();
    chk_cnt++;
    if ({dtack_n, region_cs} !== 5'b1_0000)
      $display("FAIL ext_release: dtack/cs=%b required 10000", {dtack_n, region_cs});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_unmapped();
    logic bad;
    cpu_a = 24'h200000; cpu_as_n = 1'b0; cpu_lds_n = 1'b0;
    tick();
    chk_cnt++;
    if ({region_cs, hit} !== 5'b0000_0)
      $display("FAIL unmap_decode: cs/hit=%b required 00000", {region_cs, hit});
    else pass_cnt++;
    bad = 1'b0;
    for (int k = 1; k <= 254; k++) begin
      tick();
      if (berr_n !== 1'b1 || dtack_n !== 1'b1) bad = 1'b1;
    end
    chk_cnt++;
    if (bad)
      $display("FAIL unmap_early_berr: berr/dtack=%b required 11 before 255 cycles", {berr_n, dtack_n});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({berr_n, dtack_n} !== 2'b01)
      $display("FAIL unmap_berr: berr/dtack=%b required 01 at 255 cycles", {berr_n, dtack_n});
    else pass_cnt++;
    repeat (3) tick();
    chk_cnt++;
    if ({berr_n, dtack_n} !== 2'b01)
      $display("FAIL unmap_berr_hold: berr/dtack=%b required 01", {berr_n, dtack_n});
    else pass_cnt++;
    bus_idle();
    tick();
    chk_cnt++;
    if (berr_n !== 1'b1)
      $display("FAIL unmap_release: berr=%b required 1", berr_n);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_ext_timeout();
    int  first_berr;
    logic saw_dtack;
    cpu_a = 24'h0B0010; cpu_as_n = 1'b0; cpu_uds_n = 1'b0; ext_ready = 1'b0;
    tick();
    first_berr = -1;
    saw_dtack  = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (berr_n === 1'b0 && first_berr < 0) first_berr = k;
      if (dtack_n !== 1'b1) saw_dtack = 1'b1;
    end
    chk_cnt++;
    if (first_berr != 255)
      $display("FAIL ext_timeout_cycle: berr fell at cycle %0d required 255", first_berr);
    else pass_cnt++;
    chk_cnt++;
    if (saw_dtack)
      $display("FAIL ext_timeout_dtack: dtack went low required always 1");
    else pass_cnt++;
    bus_idle();
    tick();
    chk_cnt++;
    if ({berr_n, dtack_n} !== 2'b11)
      $display("FAIL ext_timeout_release: berr/dtack=%b required 11", {berr_n, dtack_n});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_abort();
    logic bad;
    cpu_a = 24'h0B0010; cpu_as_n = 1'b0; cpu_uds_n = 1'b0; ext_ready = 1'b0;
    tick();
    tick();
    bus_idle();
    tick();
    chk_cnt++;
    if ({region_cs, hit, dtack_n, berr_n} !== 7'b0000_0_1_1)
      $display("FAIL abort_clear: cs/hit/dtack/berr=%b required 0000011", {region_cs, hit, dtack_n, berr_n});
    else pass_cnt++;
    ext_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dtack_n !== 1'b1 || region_cs !== 4'b0000) bad = 1'b1;
    end
    chk_cnt++;
    if (bad)
      $display("FAIL abort_no_ack: dtack/cs=%b required 10000", {dtack_n, region_cs});
    else pass_cnt++;
    ext_ready = 1'b0;
  endtask

  task automatic test_reset_in_ack();
    cpu_a = 24'h001234; cpu_as_n = 1'b0; cpu_uds_n = 1'b0;
    tick();
    tick();
    chk_cnt++;
    if (dtack_n !== 1'b0)
      $display("FAIL rst_ack_setup: dtack=%b required 0", dtack_n);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if ({dtack_n, region_cs, hit, berr_n} !== 7'b1_0000_0_1)
      $display("FAIL rst_async: dtack/cs/hit/berr=%b required 1000001", {dtack_n, region_cs, hit, berr_n});
    else pass_cnt++;
    bus_idle();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_no_strobe();
    logic bad;
    cpu_a = 24'h001234; cpu_as_n = 1'b0; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({region_cs, hit, dtack_n, berr_n} !== 7'b0000_0_1_1) bad = 1'b1;
    end
    chk_cnt++;
    if (bad)
      $display("FAIL no_strobe: cs/hit/dtack/berr=%b required 0000011", {region_cs, hit, dtack_n, berr_n});
    else pass_cnt++;
    bus_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    cpu_a = 24'h001234; cpu_as_n = 1'b0; cpu_uds_n = 1'b0;
    tick();
    tick();
    cpu_as_n = 1'b1; cpu_uds_n = 1'b1;
    tick();
    cpu_a = 24'h070100; cpu_as_n = 1'b0; cpu_lds_n = 1'b0;
    tick();
    chk_cnt++;
    if ({region_cs, region_idx, hit} !== 7'b0010_01_1)
      $display("FAIL b2b_decode: cs/idx/hit=%b required 0010011", {region_cs, region_idx, hit});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({dtack_n, region_cs} !== 5'b0_0010)
      $display("FAIL b2b_ack: dtack/cs=%b required 00010", {dtack_n, region_cs});
    else pass_cnt++;
    bus_idle();
    tick();
    tick();
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    reset    = 1'b1;
    cpu_a    = 24'h000000;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    tick();
    test_read_r0();
    test_wait_r2();
    test_ext_ready();
    test_unmapped();
    test_ext_timeout();
    test_abort();
    test_reset_in_ack();
    test_no_strobe();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
